// File: rtl/anneal_accept.sv
// Metropolis-style accept/reject for one annealing trial: threshold = sat((temp*exprv)>>FRAC_BITS),
// product built by a serial shift-add. Optional statistics counters under `ifdef ACCEPT_STATS_EN.
module anneal_accept #(
  parameter int RV_DATA_WIDTH = 16,
  parameter int FRAC_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [RV_DATA_WIDTH-1:0] delta_e,
  input  logic [RV_DATA_WIDTH-1:0] temp,
  input  logic [RV_DATA_WIDTH-1:0] exprv,
  output logic                     rv_enable,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     accept,
  output logic [RV_DATA_WIDTH-1:0] threshold,
  input  logic                     stats_clr,
  output logic [15:0]              trial_cnt,
  output logic [15:0]              accept_cnt,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready is high only in IDLE; resp_valid is high only in DONE and the response holds until taken.

  localparam int W  = RV_DATA_WIDTH;
  localparam int P  = 2 * RV_DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [P-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [P-1:0]  r_acc;
  logic [W-1:0]  r_delta;
  logic [CW-1:0] r_step;
  logic          r_rv_en;
  logic          r_accept;
  logic [W-1:0]  r_thr;

  logic          w_capture;
  logic          w_hs;
  logic          w_delta_le0;
  logic [P-1:0]  w_acc_next;
  logic [P-1:0]  w_shifted;
  logic [W-1:0]  w_thr;

  assign w_capture   = (r_state == IDLE) && req_valid;
  assign w_hs        = (r_state == DONE) && resp_ready;
  assign w_delta_le0 = delta_e[W-1] || (delta_e == '0);

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_shifted  = w_acc_next >> FRAC_BITS;
  assign w_thr      = (|w_shifted[P-1:W]) ? '1 : w_shifted[W-1:0];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_state_next = w_delta_le0 ? DONE : MUL;
      MUL:  if (r_step == LAST_STEP) w_state_next = DONE;
      DONE: if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_delta  <= '0;
      r_step   <= '0;
      r_rv_en  <= 1'b0;
      r_accept <= 1'b0;
      r_thr    <= '0;
    end else begin
      r_rv_en <= w_capture;
      if (w_capture) begin
        r_mcand  <= {{W{1'b0}}, temp};
        r_mplier <= exprv;
        r_delta  <= delta_e;
        r_acc    <= '0;
        r_step   <= '0;
        r_accept <= w_delta_le0;
        r_thr    <= '0;
      end else if (r_state == MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_step   <= r_step + 1'b1;
        // The last step latches the decision from the completed product.
        if (r_step == LAST_STEP) begin
          r_thr    <= w_thr;
          r_accept <= (r_delta < w_thr);
        end
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign rv_enable  = r_rv_en;
  assign accept     = r_accept;
  assign threshold  = r_thr;
  assign dbg_state  = r_state;

`ifdef ACCEPT_STATS_EN
  logic [15:0] r_trial_cnt;
  logic [15:0] r_accept_cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_trial_cnt  <= '0;
      r_accept_cnt <= '0;
    end else if (stats_clr) begin
      r_trial_cnt  <= '0;
      r_accept_cnt <= '0;
    end else if (w_hs) begin
      if (r_trial_cnt != 16'hFFFF) r_trial_cnt <= r_trial_cnt + 16'd1;
      if (r_accept && (r_accept_cnt != 16'hFFFF)) r_accept_cnt <= r_accept_cnt + 16'd1;
    end
  end

  assign trial_cnt  = r_trial_cnt;
  assign accept_cnt = r_accept_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = stats_clr ^ w_hs;
  assign trial_cnt  = 16'd0;
  assign accept_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_anneal_accept.sv
// Self-checking bench for anneal_accept: scoreboard of expected {accept, threshold, latency},
// directed boundary trials, backpressure, mid-trial reset and (when enabled) statistics.
module tb_anneal_accept;

  logic        clk;
  logic        reset_l;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] delta_e;
  logic [15:0] temp;
  logic [15:0] exprv;
  logic        rv_enable;
  logic        resp_valid;
  logic        resp_ready;
  logic        accept;
  logic [15:0] threshold;
  logic        stats_clr;
  logic [15:0] trial_cnt;
  logic [15:0] accept_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] exp_trial = 16'd0;
  logic [15:0] exp_acc   = 16'd0;

  anneal_accept dut (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid), .req_ready(req_ready),
    .delta_e(delta_e), .temp(temp), .exprv(exprv),
    .rv_enable(rv_enable),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .accept(accept), .threshold(threshold),
    .stats_clr(stats_clr),
    .trial_cnt(trial_cnt), .accept_cnt(accept_cnt),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string name);
    total++;
    if (trial_cnt !== exp_trial || accept_cnt !== exp_acc) begin
      bad++;
      $display("FAIL %s: trial_cnt=%h accept_cnt=%h expected %h %h", name, trial_cnt, accept_cnt, exp_trial, exp_acc);
    end
  endtask

  // Push the model's expectation, run one trial, pop and compare when the response appears.
  task automatic do_trial(input logic [15:0] d, input logic [15:0] t, input logic [15:0] e,
                          input bit clr_at_hs, input string name);
    logic [31:0] prod;
    logic [31:0] sh;
    logic [15:0] thr;
    logic        acc;
    logic [16:0] got;
    int          exp_lat;
    int          lat;
    if (d[15] || d == 16'd0) begin
      thr = 16'd0; acc = 1'b1; exp_lat = 1;
    end else begin
      prod = {16'd0, t} * {16'd0, e};
      sh   = prod >> 8;
      thr  = (sh > 32'h0000FFFF) ? 16'hFFFF : sh[15:0];
      acc  = (d < thr);
      exp_lat = 17;
    end
    exp_q.push_back({acc, thr});
    lat_q.push_back(exp_lat);

    req_valid = 1'b1; delta_e = d; temp = t; exprv = e;
    tick();
    req_valid = 1'b0;
    delta_e = 16'(~d); temp = 16'($urandom); exprv = 16'($urandom);
    lat = 1;
    total++;
    if (rv_enable !== 1'b1) begin
      bad++; $display("FAIL %s rv_pulse: rv_enable=%b expected 1", name, rv_enable);
    end
    while (resp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      total++;
      if (rv_enable !== 1'b0) begin
        bad++; $display("FAIL %s rv_low: rv_enable=%b at cycle %0d expected 0", name, rv_enable, lat);
      end
    end
    exp_lat = lat_q.pop_front();
    total++;
    if (lat !== exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, exp_lat);
    end
    got = {accept, threshold};
    total++;
    if (got !== exp_q[0]) begin
      bad++; $display("FAIL %s decision: accept=%b threshold=%h expected accept=%b threshold=%h",
                      name, accept, threshold, exp_q[0][16], exp_q[0][15:0]);
    end
    void'(exp_q.pop_front());

    resp_ready = 1'b1;
    stats_clr  = clr_at_hs;
    tick();
    resp_ready = 1'b0;
    stats_clr  = 1'b0;
`ifdef ACCEPT_STATS_EN
    if (clr_at_hs) begin
      exp_trial = 16'd0; exp_acc = 16'd0;
    end else begin
      if (exp_trial != 16'hFFFF) exp_trial = exp_trial + 16'd1;
      if (acc && exp_acc != 16'hFFFF) exp_acc = exp_acc + 16'd1;
    end
`endif
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL %s back_to_idle: req_ready=%b resp_valid=%b expected 1 0", name, req_ready, resp_valid);
    end
    check_counters({name, " counters"});
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || accept !== 1'b0 || threshold !== 16'd0 ||
        rv_enable !== 1'b0 || dbg_state !== 2'd0 || trial_cnt !== 16'd0 || accept_cnt !== 16'd0) begin
      bad++;
      $display("FAIL %s: req_ready=%b resp_valid=%b accept=%b threshold=%h rv_enable=%b state=%0d cnt=%h/%h expected 1 0 0 0000 0 0 0000/0000",
               name, req_ready, resp_valid, accept, threshold, rv_enable, dbg_state, trial_cnt, accept_cnt);
    end
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    #1 reset_l = 1'b1;
    tick();
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_nonpositive();
    do_trial(16'hFFFB, 16'h0100, 16'h0200, 1'b0, "neg_delta");
    do_trial(16'h0000, 16'h0100, 16'h0200, 1'b0, "zero_delta");
  endtask

  task automatic test_threshold_edge();
    do_trial(16'h0003, 16'h0004, 16'h0100, 1'b0, "below_thr");
    do_trial(16'h0004, 16'h0004, 16'h0100, 1'b0, "equal_rejects");
    do_trial(16'h0001, 16'h0000, 16'h1234, 1'b0, "temp_zero");
    do_trial(16'h0001, 16'h1234, 16'h0000, 1'b0, "exprv_zero");
  endtask

  task automatic test_saturation();
    do_trial(16'h7FFF, 16'hFFFF, 16'hFFFF, 1'b0, "saturate");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      do_trial(16'($urandom_range(0, 16'h7FFF)), 16'($urandom_range(0, 16'hFFFF)),
               16'($urandom_range(0, 16'h0FFF)), 1'b0, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] thr_hold;
    logic        acc_hold;
    int          guard;
    req_valid = 1'b1; delta_e = 16'h0003; temp = 16'h0004; exprv = 16'h0100;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    total++;
    if (resp_valid !== 1'b1) begin
      bad++; $display("FAIL bp_resp_timeout: resp_valid=%b expected 1", resp_valid);
    end
    thr_hold = 16'h0004; acc_hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; delta_e = 16'hFFFF; temp = 16'($urandom); exprv = 16'($urandom);
      tick();
      total++;
      if (accept !== acc_hold || threshold !== thr_hold || req_ready !== 1'b0 ||
          resp_valid !== 1'b1 || dbg_state !== 2'd2) begin
        bad++;
        $display("FAIL bp_hold[%0d]: accept=%b threshold=%h req_ready=%b resp_valid=%b state=%0d expected 1 0004 0 1 2",
                 c, accept, threshold, req_ready, resp_valid, dbg_state);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
`ifdef ACCEPT_STATS_EN
    exp_trial = exp_trial + 16'd1; exp_acc = exp_acc + 16'd1;
`endif
    total++;
    if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL bp_release: req_ready=%b state=%0d expected 1 0", req_ready, dbg_state);
    end
    check_counters("bp_counters");
  endtask

  task automatic test_reset_mid_mul();
    req_valid = 1'b1; delta_e = 16'h0001; temp = 16'h0400; exprv = 16'h0400;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    total++;
    if (dbg_state !== 2'd1) begin
      bad++; $display("FAIL mid_mul_state: state=%0d expected 1", dbg_state);
    end
    reset_l = 1'b0;
    #1;
    exp_trial = 16'd0; exp_acc = 16'd0;
    check_reset_outputs("reset_mid_mul");
    @(posedge clk);
    #1 reset_l = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL no_resp_after_abort[%0d]: resp_valid=%b req_ready=%b expected 0 1", c, resp_valid, req_ready);
      end
    end
    check_counters("abort_counters");
  endtask

  task automatic test_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`ifdef ACCEPT_STATS_EN
    exp_trial = 16'd0; exp_acc = 16'd0;
`endif
    check_counters("stats_clr_idle");
    do_trial(16'hFFFF, 16'h0010, 16'h0010, 1'b0, "stats_a1");
    do_trial(16'h0003, 16'h0004, 16'h0100, 1'b0, "stats_a2");
    do_trial(16'h0004, 16'h0004, 16'h0100, 1'b0, "stats_r1");
    do_trial(16'h0000, 16'h0000, 16'h0000, 1'b0, "stats_a3");
    do_trial(16'h0001, 16'h0000, 16'h0100, 1'b0, "stats_r2");
`ifdef ACCEPT_STATS_EN
    total++;
    if (trial_cnt !== 16'd5 || accept_cnt !== 16'd3) begin
      bad++; $display("FAIL stats_5_3: trial_cnt=%0d accept_cnt=%0d expected 5 3", trial_cnt, accept_cnt);
    end
`endif
    do_trial(16'hFFF0, 16'h0001, 16'h0001, 1'b1, "stats_clr_hs");
  endtask

  initial begin
    reset_l = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; stats_clr = 1'b0;
    delta_e = '0; temp = '0; exprv = '0;
    test_reset();
    test_nonpositive();
    test_threshold_edge();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
    test_stats();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/anneal_accept.md
ANNEAL_ACCEPT -- requirements
Module: anneal_accept

Interface
REQ-001 The block SHALL have parameter RV_DATA_WIDTH, default 16, setting the width of exprv, temp, delta_e and threshold.
REQ-002 The block SHALL have parameter FRAC_BITS, default 8, giving the number of fractional bits of exprv (Q8.8 by default).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_l  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  a trial is offered.
REQ-006 req_ready  output  1  block can accept a trial.
REQ-007 delta_e  input  RV_DATA_WIDTH  signed two's-complement energy change of the proposed flip.
REQ-008 temp  input  RV_DATA_WIDTH  unsigned annealing temperature.
REQ-009 exprv  input  RV_DATA_WIDTH  unsigned exponential random variate from the upstream LFSR/log-LUT stage.
REQ-010 rv_enable  output  1  one-cycle pulse that advances the upstream LFSR.
REQ-011 resp_valid  output  1  decision available.
REQ-012 resp_ready  input  1  consumer takes the decision.
REQ-013 accept  output  1  1 = flip accepted; valid while resp_valid is high.
REQ-014 threshold  output  RV_DATA_WIDTH  saturated (temp*exprv)>>FRAC_BITS used for the decision.
REQ-015 stats_clr  input  1  synchronous clear of the statistics counters.
REQ-016 trial_cnt, accept_cnt  output  16 each  statistics counters.

Function
REQ-017 The block SHALL implement states IDLE, MUL, DONE; req_ready SHALL be 1 exactly in IDLE.
REQ-018 On req_valid&&req_ready, the block SHALL register delta_e, temp and exprv in that cycle (cycle 0).
REQ-019 rv_enable SHALL be high for exactly cycle 1 after each capture and low otherwise.
REQ-020 If captured delta_e <= 0: go to DONE with accept=1 and threshold=0; resp_valid high from cycle 1.
REQ-021 If delta_e > 0: enter MUL and compute temp*exprv as an unsigned 2*RV_DATA_WIDTH product by one shift-add step per cycle (RV_DATA_WIDTH cycles, cycles 1..16 by default); then go to DONE with resp_valid high from cycle 17.
REQ-022 threshold SHALL be product>>FRAC_BITS, saturated to all-ones if it exceeds RV_DATA_WIDTH bits.
REQ-023 accept SHALL be 1 iff unsigned delta_e < threshold; equality SHALL reject.
REQ-024 temp=0 or exprv=0 with delta_e>0: threshold 0, accept 0, full MUL latency still applies.
REQ-025 In DONE, accept, threshold and resp_valid SHALL hold stable until resp_valid&&resp_ready; the block SHALL then return to IDLE in the next cycle.
REQ-026 req_valid SHALL be ignored outside IDLE; a back-to-back trial is captured no earlier than the cycle after the response handshake.
REQ-027 Input changes on delta_e, temp and exprv after capture SHALL NOT affect the in-flight decision.

Reset
REQ-028 reset_l low SHALL immediately force state IDLE, req_ready 1, resp_valid 0, accept 0, threshold 0, rv_enable 0, product/operand registers 0, counters 0.
REQ-029 Reset asserted mid-MUL or in DONE SHALL abort the trial without a response or counter update.

Configuration
REQ-030 With ACCEPT_STATS_EN defined: trial_cnt SHALL increment on every response handshake and accept_cnt on each handshake with accept=1.
- Both counters saturate at 0xFFFF.
- stats_clr zeroes both counters and takes priority over a same-cycle increment.
REQ-031 Without ACCEPT_STATS_EN: trial_cnt and accept_cnt SHALL be constant 0, stats_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-032 delta_e=-5, temp=0x0100, exprv=0x0200 -> resp_valid at cycle 1, accept=1, threshold=0, rv_enable pulse at cycle 1.
REQ-033 delta_e=3, temp=0x0004, exprv=0x0100 -> threshold=4, accept=1 at cycle 17; delta_e=4, same operands -> accept=0 (equality rejects).
REQ-034 temp=0xFFFF, exprv=0xFFFF, delta_e=0x7FFF -> threshold=0xFFFF (saturated), accept=1.
REQ-035 resp_ready held low 10 cycles in DONE -> accept and threshold stable, req_ready=0, second req_valid ignored; release -> IDLE next cycle.
REQ-036 reset_l pulsed low at cycle 8 of MUL -> all outputs reset immediately, no response; with ACCEPT_STATS_EN, 3 accepted + 2 rejected trials -> trial_cnt=5, accept_cnt=3; stats_clr together with a handshake -> both 0.
